// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load_op bit
// positions and the execute-to-memory bus layout.
package mem_stage_pkg;

  localparam int EXE_to_MEM_LEN = 112;
  localparam int MEM_to_WB_LEN  = 70;
  localparam int MEM_RF_LEN     = 37;
  localparam int DEST_LEN       = 5;

  // load_op is one-hot {ld_b, ld_bu, ld_h, ld_hu}; all-zero on a load is ld_w
  localparam int LD_B  = 3;
  localparam int LD_BU = 2;
  localparam int LD_H  = 1;
  localparam int LD_HU = 0;

  typedef struct packed {
    logic [31:0]         pc;
    logic                gr_we;
    logic [DEST_LEN-1:0] dest;
    logic [31:0]         exe_result;
    logic [31:0]         mem_sum;
    logic                mem_en;
    logic [3:0]          mem_we;
    logic [3:0]          load_op;
    logic                rfrom_mem;
  } exe_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the byte/half/word addressed by addr
// out of the SRAM read word and sign- or zero-extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [1:0]  addr_i,
  input  logic [3:0]  load_op_i,
  input  logic        rfrom_mem_i,
  output logic [31:0] load_val_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; the half select ignores addr[0] so misaligned halves still read a lane
  always_comb begin
    byte_s = rword_i[{addr_i, 3'b000} +: 8];
    if (addr_i[1]) begin
      half_s = rword_i[31:16];
    end else begin
      half_s = rword_i[15:0];
    end
  end

  // Extension by load type; non-loads produce zero since the top selects exe_result
  always_comb begin
    load_val_o = 32'd0;
    if (!rfrom_mem_i) begin
      load_val_o = 32'd0;
    end else if (load_op_i[LD_B]) begin
      load_val_o = {{24{byte_s[7]}}, byte_s};
    end else if (load_op_i[LD_BU]) begin
      load_val_o = {24'd0, byte_s};
    end else if (load_op_i[LD_H]) begin
      load_val_o = {{16{half_s[15]}}, half_s};
    end else if (load_op_i[LD_HU]) begin
      load_val_o = {16'd0, half_s};
    end else begin
      load_val_o = rword_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Registers the execute bus under the
// valid/allowin handshake, holds the SRAM read word across stalls, aligns
// loads and drives the write-back and register-file forwarding buses.
// Optional feature macro: MEM_ALE_CHECK_EN adds the mem_ale misaligned-load
// flag and suppresses register write-back for flagged loads.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [EXE_to_MEM_LEN-1:0] EXE_to_MEM_BUS,
  input  logic                      EXE_to_MEM_valid,
  input  logic                      WB_allowin,
  input  logic [31:0]               data_sram_rdata,
  output logic                      MEM_allowin,
  output logic                      MEM_to_WB_valid,
  output logic [MEM_to_WB_LEN-1:0]  MEM_to_WB_BUS,
  output logic [MEM_RF_LEN-1:0]     MEM_RF_BUS
`ifdef MEM_ALE_CHECK_EN
  ,
  output logic                      mem_ale
`endif
);

  logic        mem_valid_q,  mem_valid_d;
  exe_to_mem_t bus_q,        bus_d;
  logic        first_cyc_q,  first_cyc_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;

  exe_to_mem_t         exe_bus_s;
  logic                mem_allowin_s;
  logic                accept_s;
  logic [31:0]         rword_s;
  logic [31:0]         load_val_s;
  logic [31:0]         final_result_s;
  logic                ale_s;
  logic                wb_gr_we_s;
  logic [DEST_LEN-1:0] rf_dest_s;
  logic                unused_bus_s;

  assign exe_bus_s     = exe_to_mem_t'(EXE_to_MEM_BUS);
  assign mem_allowin_s = !mem_valid_q || WB_allowin;
  assign accept_s      = EXE_to_MEM_valid && mem_allowin_s;
  assign unused_bus_s  = ^{bus_q.mem_sum, bus_q.mem_en, bus_q.mem_we};

  // Next-state: handshake, bus capture on accept, and SRAM word hold after the first cycle
  always_comb begin
    mem_valid_d  = mem_valid_q;
    bus_d        = bus_q;
    first_cyc_d  = accept_s;
    rdata_hold_d = rdata_hold_q;
    if (mem_allowin_s) begin
      mem_valid_d = EXE_to_MEM_valid;
    end else begin
      mem_valid_d = mem_valid_q;
    end
    if (accept_s) begin
      bus_d = exe_bus_s;
    end else begin
      bus_d = bus_q;
    end
    if (first_cyc_q) begin
      rdata_hold_d = data_sram_rdata;
    end else begin
      rdata_hold_d = rdata_hold_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      bus_q        <= '0;
      first_cyc_q  <= 1'b0;
      rdata_hold_q <= 32'd0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      bus_q        <= bus_d;
      first_cyc_q  <= first_cyc_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // The live SRAM word is only trustworthy in the cycle right after the request edge
  assign rword_s = first_cyc_q ? data_sram_rdata : rdata_hold_q;

  mem_stage_load_align load_align (
    .rword_i     (rword_s),
    .addr_i      (bus_q.exe_result[1:0]),
    .load_op_i   (bus_q.load_op),
    .rfrom_mem_i (bus_q.rfrom_mem),
    .load_val_o  (load_val_s)
  );

`ifdef MEM_ALE_CHECK_EN
  logic half_ld_s;
  logic word_ld_s;
  assign half_ld_s = bus_q.load_op[LD_H] || bus_q.load_op[LD_HU];
  assign word_ld_s = (bus_q.load_op == 4'b0000);
  assign ale_s     = mem_valid_q && bus_q.rfrom_mem &&
                     ((half_ld_s && bus_q.exe_result[0]) ||
                      (word_ld_s && (bus_q.exe_result[1:0] != 2'b00)));
  assign mem_ale   = ale_s;
`else
  assign ale_s = 1'b0;
`endif

  // Result selection and write-enable/destination masking for bubbles and faulting loads
  always_comb begin
    final_result_s = bus_q.exe_result;
    wb_gr_we_s     = bus_q.gr_we && !ale_s;
    rf_dest_s      = {DEST_LEN{1'b0}};
    if (bus_q.rfrom_mem) begin
      final_result_s = load_val_s;
    end else begin
      final_result_s = bus_q.exe_result;
    end
    if (wb_gr_we_s && mem_valid_q) begin
      rf_dest_s = bus_q.dest;
    end else begin
      rf_dest_s = {DEST_LEN{1'b0}};
    end
  end

  assign MEM_allowin     = mem_allowin_s;
  assign MEM_to_WB_valid = mem_valid_q;
  assign MEM_to_WB_BUS   = {bus_q.pc, wb_gr_we_s, bus_q.dest, final_result_s};
  assign MEM_RF_BUS      = {rf_dest_s, final_result_s};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver offers ops and pushes the
// expected write-back record on each accept; a monitor compares at negedge.
module tb_mem_stage;

  typedef logic [111:0] cmp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ale;
  } exp_t;

  typedef struct {
    logic [111:0] bus;
    logic [31:0]  word;
    bit           stall;
    exp_t         exp;
  } stim_t;

`ifdef MEM_ALE_CHECK_EN
  localparam bit ALE_EN = 1'b1;
`else
  localparam bit ALE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic [111:0] exe_bus;
  logic         exe_valid;
  logic         wb_allowin;
  logic [31:0]  rdata;
  logic         mem_allowin;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_bus;
  logic [36:0]  mem_rf_bus;
`ifdef MEM_ALE_CHECK_EN
  logic         mem_ale;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  stim_t cur;
  bit    have_cur      = 1'b0;
  bit    just_accepted = 1'b0;
  logic [31:0] acc_word = 32'd0;
  int    wb_stall_cnt  = 0;
  bit    random_wb     = 1'b0;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .EXE_to_MEM_BUS   (exe_bus),
    .EXE_to_MEM_valid (exe_valid),
    .WB_allowin       (wb_allowin),
    .data_sram_rdata  (rdata),
    .MEM_allowin      (mem_allowin),
    .MEM_to_WB_valid  (mem_to_wb_valid),
    .MEM_to_WB_BUS    (mem_to_wb_bus),
    .MEM_RF_BUS       (mem_rf_bus)
`ifdef MEM_ALE_CHECK_EN
    ,
    .mem_ale          (mem_ale)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(string name, cmp_t act, cmp_t expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // kind: 0 alu, 1 store, 2 ld_b, 3 ld_bu, 4 ld_h, 5 ld_hu, 6 ld_w
  function automatic stim_t make_op(int kind, logic [31:0] addr, logic [31:0] word,
                                    logic gr_we, logic [4:0] dest, bit stall);
    stim_t s;
    logic [31:0] pc, msum, b, h, res;
    logic [3:0]  lop;
    logic        rfm, ale;
    pc   = $urandom;
    msum = $urandom;
    rfm  = (kind >= 2);
    case (kind)
      2:       lop = 4'b1000;
      3:       lop = 4'b0100;
      4:       lop = 4'b0010;
      5:       lop = 4'b0001;
      default: lop = 4'b0000;
    endcase
    b = (word >> (8 * addr[1:0])) & 32'h0000_00FF;
    h = (word >> (16 * addr[1])) & 32'h0000_FFFF;
    case (kind)
      2:       res = (b >= 32'h80)   ? b - 32'h100   : b;
      3:       res = b;
      4:       res = (h >= 32'h8000) ? h - 32'h10000 : h;
      5:       res = h;
      6:       res = word;
      default: res = addr;
    endcase
    ale = ALE_EN && (((kind == 4 || kind == 5) && addr[0]) ||
                     (kind == 6 && addr[1:0] != 2'b00));
    s.bus   = {pc, gr_we, dest, addr, msum, (kind >= 1), (kind == 1) ? 4'hF : 4'h0, lop, rfm};
    s.word  = word;
    s.stall = stall;
    s.exp   = '{pc: pc, gr_we: gr_we && !ale, dest: dest, result: res, ale: ale};
    return s;
  endfunction

  // One clock of driving; entered and left at posedge+1
  task automatic run_cycle();
    bit accept;
    if (!have_cur && stim_q.size() != 0 && (!random_wb || $urandom_range(0, 3) != 0)) begin
      cur      = stim_q.pop_front();
      have_cur = 1'b1;
    end
    exe_valid = have_cur;
    exe_bus   = have_cur ? cur.bus : {$urandom, $urandom, $urandom, $urandom};
    if (wb_stall_cnt > 0) begin
      wb_allowin = 1'b0;
      wb_stall_cnt--;
    end else begin
      wb_allowin = random_wb ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    rdata = just_accepted ? acc_word : (random_wb ? $urandom : 32'hDEAD_BEEF);
    @(negedge clk);
    accept = exe_valid && mem_allowin;
    @(posedge clk);
    just_accepted = accept;
    if (accept) begin
      exp_q.push_back(cur.exp);
      acc_word = cur.word;
      have_cur = 1'b0;
      if (cur.stall) wb_stall_cnt = 3;
    end
    #1;
  endtask

  task automatic run_until_idle(int bound);
    for (int i = 0; i < bound && (stim_q.size() != 0 || have_cur); i++) run_cycle();
    run_cycle();
    run_cycle();
  endtask

  // Monitor: compares handshake and buses against the scoreboard head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && mon_en) begin
      check("allowin", cmp_t'(mem_allowin), cmp_t'(exp_q.size() == 0 || wb_allowin));
      check("wb_valid", cmp_t'(mem_to_wb_valid), cmp_t'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("wb_bus", cmp_t'(mem_to_wb_bus), cmp_t'({e.pc, e.gr_we, e.dest, e.result}));
        check("rf_bus", cmp_t'(mem_rf_bus), cmp_t'({e.gr_we ? e.dest : 5'd0, e.result}));
`ifdef MEM_ALE_CHECK_EN
        check("mem_ale", cmp_t'(mem_ale), cmp_t'(e.ale));
`endif
        if (wb_allowin) void'(exp_q.pop_front());
      end else begin
        check("rf_dest_bubble", cmp_t'(mem_rf_bus[36:32]), cmp_t'(5'd0));
`ifdef MEM_ALE_CHECK_EN
        check("mem_ale_bubble", cmp_t'(mem_ale), cmp_t'(1'b0));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    exe_valid  = 1'b0;
    exe_bus    = '0;
    wb_allowin = 1'b0;
    rdata      = 32'd0;
    #3;
    check("rst_valid",   cmp_t'(mem_to_wb_valid), cmp_t'(1'b0));
    check("rst_allowin", cmp_t'(mem_allowin),     cmp_t'(1'b1));
    check("rst_wb_bus",  cmp_t'(mem_to_wb_bus),   cmp_t'(70'd0));
    check("rst_rf_bus",  cmp_t'(mem_rf_bus),      cmp_t'(37'd0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    // Directed load extraction cases
    stim_q.push_back(make_op(2, 32'h0000_1003, 32'h80FF_1234, 1'b1, 5'd3, 1'b0));
    stim_q.push_back(make_op(3, 32'h0000_1003, 32'h80FF_1234, 1'b1, 5'd4, 1'b0));
    stim_q.push_back(make_op(4, 32'h0000_1002, 32'h8001_7FFF, 1'b1, 5'd5, 1'b0));
    stim_q.push_back(make_op(5, 32'h0000_1000, 32'h8001_7FFF, 1'b1, 5'd6, 1'b0));
    // Stalled load must keep its captured word
    stim_q.push_back(make_op(6, 32'h0000_1000, 32'h1234_5678, 1'b1, 5'd7, 1'b1));
    // Back-to-back ALU ops, one without register write
    stim_q.push_back(make_op(0, 32'hA5A5_0001, 32'd0, 1'b1, 5'd8,  1'b0));
    stim_q.push_back(make_op(0, 32'hA5A5_0002, 32'd0, 1'b1, 5'd9,  1'b0));
    stim_q.push_back(make_op(0, 32'hA5A5_0003, 32'd0, 1'b0, 5'd10, 1'b0));
    stim_q.push_back(make_op(0, 32'hA5A5_0004, 32'd0, 1'b1, 5'd11, 1'b0));
    stim_q.push_back(make_op(1, 32'h0000_2000, 32'd0, 1'b0, 5'd0,  1'b0));
`ifdef MEM_ALE_CHECK_EN
    stim_q.push_back(make_op(6, 32'h0000_1002, 32'hCAFE_F00D, 1'b1, 5'd12, 1'b0));
    stim_q.push_back(make_op(6, 32'h0000_1004, 32'hCAFE_F00D, 1'b1, 5'd13, 1'b0));
`endif
    run_until_idle(100);

    // Asynchronous reset in the middle of a stall
    stim_q.push_back(make_op(6, 32'h0000_1000, 32'h0BAD_F00D, 1'b1, 5'd14, 1'b1));
    run_cycle();
    run_cycle();
    resetn    = 1'b0;
    exe_valid = 1'b0;
    #2;
    check("midrst_valid",   cmp_t'(mem_to_wb_valid), cmp_t'(1'b0));
    check("midrst_allowin", cmp_t'(mem_allowin),     cmp_t'(1'b1));
    check("midrst_wb_bus",  cmp_t'(mem_to_wb_bus),   cmp_t'(70'd0));
    check("midrst_rf_bus",  cmp_t'(mem_rf_bus),      cmp_t'(37'd0));
    exp_q.delete();
    stim_q.delete();
    have_cur      = 1'b0;
    just_accepted = 1'b0;
    wb_stall_cnt  = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    stim_q.push_back(make_op(0, 32'h1357_9BDF, 32'd0, 1'b1, 5'd15, 1'b0));
    stim_q.push_back(make_op(2, 32'h0000_3001, 32'h1122_C344, 1'b1, 5'd16, 1'b0));
    run_until_idle(50);

    // Randomized traffic with random write-back back-pressure
    random_wb = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int          kind;
      logic [31:0] addr;
      logic [31:0] tmp;
      kind = $urandom_range(0, 6);
      addr = $urandom;
      tmp  = $urandom;
      stim_q.push_back(make_op(kind, addr, $urandom, tmp[0] | tmp[1], tmp[8:4],
                               (tmp[15:12] == 4'd0)));
    end
    run_until_idle(2000);
    random_wb = 1'b0;
    run_cycle();
    run_cycle();
    check("drain_empty", cmp_t'(exp_q.size() + stim_q.size() + int'(have_cur)), cmp_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
